// File: rtl/des_key_schedule.sv
// Iterative DES key schedule: keeps only C/D and emits one PC-2 subkey per advance.
// Optional build macro DES_KEY_PARITY_CHECK_EN adds an odd-parity check of key_in at accept.
module des_key_schedule (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] key_in,
  input  logic        decrypt,
  input  logic        key_valid,
  output logic        key_ready,
  output logic [47:0] round_key,
  output logic        round_key_valid,
  output logic [3:0]  round_idx,
  output logic        last_round,
  input  logic        advance,
  output logic        parity_err
);

  // FIPS tables, 1-based bit numbers with bit 1 = MSB
  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state;
  logic [27:0] c, d;
  logic        dir;
  logic [55:0] cd0;
  logic [27:0] c_nxt, d_nxt;
  logic [47:0] key_nxt;
  logic        accept, step, dbl;

  // Round numbers 1, 2, 9 and 16 shift by one; all others by two.
  function automatic logic two_step(input logic [3:0] r);
    return !(r == 4'd0 || r == 4'd1 || r == 4'd8 || r == 4'd15);
  endfunction

  assign accept     = key_valid & key_ready;
  assign step       = (state == RUN) & advance & (round_idx != 4'd15);
  assign last_round = round_key_valid & (round_idx == 4'd15);

  for (genvar i = 0; i < 56; i++) begin : g_pc1
    assign cd0[55-i] = key_in[64-PC1[i]];
  end

  always_comb begin
    c_nxt = c;
    d_nxt = d;
    dbl   = 1'b0;
    if (accept) begin
      // Decrypt starts from C16/D16, which equals the unrotated C0/D0.
      if (decrypt) begin
        c_nxt = cd0[55:28];
        d_nxt = cd0[27:0];
      end else begin
        c_nxt = {cd0[54:28], cd0[55]};
        d_nxt = {cd0[26:0], cd0[27]};
      end
    end else if (step) begin
      if (!dir) begin
        dbl   = two_step(round_idx + 4'd1);
        c_nxt = dbl ? {c[25:0], c[27:26]} : {c[26:0], c[27]};
        d_nxt = dbl ? {d[25:0], d[27:26]} : {d[26:0], d[27]};
      end else begin
        dbl   = two_step(4'd15 - round_idx);
        c_nxt = dbl ? {c[1:0], c[27:2]} : {c[0], c[27:1]};
        d_nxt = dbl ? {d[1:0], d[27:2]} : {d[0], d[27:1]};
      end
    end
  end

  for (genvar i = 0; i < 48; i++) begin : g_pc2
    if (PC2[i] <= 28) begin : g_c
      assign key_nxt[47-i] = c_nxt[28-PC2[i]];
    end else begin : g_d
      assign key_nxt[47-i] = d_nxt[56-PC2[i]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      key_ready       <= 1'b1;
      round_key_valid <= 1'b0;
      round_idx       <= 4'd0;
      round_key       <= 48'd0;
      c               <= 28'd0;
      d               <= 28'd0;
      dir             <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          c               <= c_nxt;
          d               <= d_nxt;
          dir             <= decrypt;
          round_key       <= key_nxt;
          round_idx       <= 4'd0;
          round_key_valid <= 1'b1;
          key_ready       <= 1'b0;
          state           <= RUN;
        end
        RUN: if (advance) begin
          if (round_idx == 4'd15) begin
            state           <= IDLE;
            round_key_valid <= 1'b0;
            round_idx       <= 4'd0;
            key_ready       <= 1'b1;
          end else begin
            c         <= c_nxt;
            d         <= d_nxt;
            round_key <= key_nxt;
            round_idx <= round_idx + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DES_KEY_PARITY_CHECK_EN
  logic [7:0] byte_odd;
  for (genvar b = 0; b < 8; b++) begin : g_par
    assign byte_odd[b] = ^key_in[8*b +: 8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      parity_err <= 1'b0;
    else if (accept) parity_err <= ~&byte_odd;
  end
`else
  // Parity bits feed nothing in this build.
  logic unused_par;
  assign unused_par = ^{key_in[56], key_in[48], key_in[40], key_in[32],
                        key_in[24], key_in[16], key_in[8],  key_in[0]};
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_des_key_schedule.sv
// Scoreboard bench for des_key_schedule: stimulus pushes expected subkeys, a negedge monitor pops on each consumed key.
module tb_des_key_schedule;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] key_in = '0;
  logic        decrypt = 1'b0;
  logic        key_valid = 1'b0;
  logic        key_ready;
  logic [47:0] round_key;
  logic        round_key_valid;
  logic [3:0]  round_idx;
  logic        last_round;
  logic        advance = 1'b0;
  logic        parity_err;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef DES_KEY_PARITY_CHECK_EN
  localparam logic PAR_ON = 1'b1;
`else
  localparam logic PAR_ON = 1'b0;
`endif

  // Subkeys K1..K16 of key 133457799BBCDFF1, worked by hand through PC-1/shifts/PC-2
  localparam logic [47:0] KREF [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5};

  typedef struct packed {
    logic [3:0]  idx;
    logic [47:0] key;
  } exp_t;
  exp_t sb[$];

  des_key_schedule dut (
    .clk(clk), .rst_n(rst_n), .key_in(key_in), .decrypt(decrypt),
    .key_valid(key_valid), .key_ready(key_ready), .round_key(round_key),
    .round_key_valid(round_key_valid), .round_idx(round_idx),
    .last_round(last_round), .advance(advance), .parity_err(parity_err));

  always #5 clk = ~clk;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endfunction

  // Monitor: every key the consumer takes must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && round_key_valid && advance) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 64'(round_idx), 64'hFFFF);
      end else begin
        e = sb.pop_front();
        chk("mon_idx", 64'(round_idx), 64'(e.idx));
        chk("mon_key", 64'(round_key), 64'(e.key));
        chk("mon_last", 64'(last_round), 64'(e.idx == 4'd15));
      end
    end
  end

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_ready"}, 64'(key_ready), 64'd1);
    chk({nm, "_valid"}, 64'(round_key_valid), 64'd0);
    chk({nm, "_idx"}, 64'(round_idx), 64'd0);
    chk({nm, "_key"}, 64'(round_key), 64'd0);
    chk({nm, "_last"}, 64'(last_round), 64'd0);
    chk({nm, "_par"}, 64'(parity_err), 64'd0);
  endtask

  // One key through the schedule; optional stall at idx3 and abort by reset at abort_at.
  task automatic run(input logic [63:0] k, input logic dec, input logic exp_par,
                     input bit stall, input int abort_at);
    logic [47:0] ek [16];
    int t;
    for (int i = 0; i < 16; i++) ek[i] = dec ? KREF[15-i] : KREF[i];
    t = 0;
    while (!key_ready && t < 20) begin
      @(posedge clk); #2; t++;
    end
    chk("key_ready_wait", 64'(key_ready), 64'd1);
    key_in = k; decrypt = dec; key_valid = 1'b1;
    @(posedge clk); #1;
    key_valid = 1'b0;
    #1;
    chk("first_valid", 64'(round_key_valid), 64'd1);
    chk("first_idx", 64'(round_idx), 64'd0);
    chk("first_key", 64'(round_key), 64'(ek[0]));
    chk("busy_ready", 64'(key_ready), 64'd0);
    chk("parity_err", 64'(parity_err), 64'(exp_par));
    for (int i = 0; i < 16; i++) begin
      if (i == abort_at) begin
        advance = 1'b0;
        @(negedge clk); #1;
        chk("pre_abort_idx", 64'(round_idx), 64'(i));
        rst_n = 1'b0;
        #1;
        chk_reset_vals("abort");
        #1 rst_n = 1'b1;
        return;
      end
      if (stall && i == 3) begin
        advance = 1'b0;
        key_in = 64'h0123456789ABCDEF; key_valid = 1'b1;
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          chk("stall_idx", 64'(round_idx), 64'd3);
          chk("stall_key", 64'(round_key), 64'(ek[3]));
          chk("stall_valid", 64'(round_key_valid), 64'd1);
          chk("stall_ready", 64'(key_ready), 64'd0);
          @(posedge clk); #2;
        end
        key_valid = 1'b0;
      end
      sb.push_back('{idx: 4'(i), key: ek[i]});
      advance = 1'b1;
      @(posedge clk); #2;
    end
    advance = 1'b0;
    chk("done_ready", 64'(key_ready), 64'd1);
    chk("done_valid", 64'(round_key_valid), 64'd0);
    chk("done_idx", 64'(round_idx), 64'd0);
    chk("done_key_hold", 64'(round_key), 64'(ek[15]));
  endtask

  initial begin
    #13;
    chk_reset_vals("reset");
    #10 rst_n = 1'b1;
    @(posedge clk); #2;

    run(64'h133457799BBCDFF1, 1'b0, 1'b0, 1'b0, 16);

    // advance while idle must not disturb anything
    advance = 1'b1;
    @(posedge clk); #2;
    advance = 1'b0;
    @(posedge clk); #2;
    chk("idle_adv_ready", 64'(key_ready), 64'd1);
    chk("idle_adv_valid", 64'(round_key_valid), 64'd0);
    chk("idle_adv_idx", 64'(round_idx), 64'd0);
    chk("idle_adv_key", 64'(round_key), 64'(KREF[15]));

    run(64'h133457799BBCDFF1, 1'b1, 1'b0, 1'b1, 16);
    run(64'h133457799BBCDFF1, 1'b0, 1'b0, 1'b0, 7);
    run(64'h133457799BBCDFF0, 1'b0, PAR_ON, 1'b0, 16);
    run(64'h133457799BBCDFF1, 1'b1, 1'b0, 1'b0, 16);

    repeat (3) @(posedge clk);
    #2;
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/des_key_schedule.md
Name: des_key_schedule

Overview:
- Iterative DES key-schedule generator that sits directly upstream of the Feistel round stage and drives its 48-bit round_key input.
- Accepts a 64-bit key with its direction (encrypt/decrypt) through a valid/ready handshake.
- Presents the 16 subkeys one per accepted advance, in K1..K16 order for encrypt and K16..K1 for decrypt.
- Holds only C/D state (56 bits) rather than storing all 16 subkeys.

Parameters:
- none (DES constants fixed: PC-1, PC-2, shift schedule 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1).

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- key_in  in  64  DES key; FIPS bit 1 = key_in[63]
- decrypt  in  1  0 = encrypt order, 1 = decrypt order; sampled with key_in
- key_valid  in  1  key_in/decrypt valid
- key_ready  out  1  block idle, will accept key
- round_key  out  48  current subkey, PC-2 output; FIPS bit 1 = round_key[47]
- round_key_valid  out  1  round_key/round_idx valid
- round_idx  out  4  0..15, position of round_key in the presented sequence
- last_round  out  1  round_key_valid & (round_idx == 15)
- advance  in  1  consumer took current round_key; move to next
- parity_err  out  1  see Optional Feature

Behaviour:
- Reset (async assert, sync release) sets:
  - state=IDLE, key_ready=1, round_key_valid=0, round_idx=0, round_key=0, C=D=0, dir=0, parity_err=0.
- States: IDLE, RUN.
- IDLE:
  - key_ready=1.
  - On key_valid&key_ready: C,D = PC-1(key_in), split into two 28-bit halves; latch dir=decrypt; go to RUN.
- Key computation at accept:
  - Encrypt: C,D rotated left by 1 and stored (C1,D1).
  - Decrypt: C,D stored unrotated (C16 = C0).
- RUN:
  - key_ready=0, round_key_valid=1.
  - round_key = PC-2(C,D) registered, so round_key is stable the whole time valid is high.
  - First valid key appears the cycle after accept: latency 1.
- advance while RUN and round_idx<15:
  - round_idx+1.
  - Encrypt: rotate C,D left by shift[round_idx+1].
  - Decrypt: rotate C,D right by shift[15-round_idx].
  - New round_key is visible the next cycle.
  - advance held high gives one subkey per cycle.
- advance while round_idx==15:
  - Back to IDLE; round_key_valid=0, round_idx=0, key_ready=1 the next cycle.
  - round_key holds its last value.
- advance while IDLE: ignored.
- key_valid while RUN: ignored (key_ready=0); no back-to-back preemption.
- Rotations are modulo 28 within each half; C and D are never mixed.
- Asserting rst_n mid-RUN aborts immediately; outputs return to reset values.
- Sequence integrity: encrypt and decrypt of the same key give mirrored subkey sequences (enc idx i == dec idx 15-i).

Optional Feature:
- Macro: DES_KEY_PARITY_CHECK_EN.
- Defined:
  - At key accept, each byte of key_in is checked for odd parity (bits 0,8,..,56 are parity bits).
  - parity_err is registered to 1 if any byte has even parity, otherwise 0.
  - It holds until the next accept or reset.
  - The key is still processed normally; there is no stall or abort.
- Undefined: parity_err tied to 0 and no checker logic is present.

Test Plan:
- Encrypt vector: key_in=64'h133457799BBCDFF1, decrypt=0, accept, advance every cycle:
  - idx0 round_key=48'h1B02EFFC7072 one cycle after accept;
  - idx15 round_key=48'hCB3D8B0E17F5 with last_round=1;
  - key_ready=1 one cycle after the final advance.
- Decrypt vector: same key, decrypt=1:
  - idx0 round_key=48'hCB3D8B0E17F5, idx15 round_key=48'h1B02EFFC7072;
  - all 16 keys equal the encrypt list reversed (compare against a reference model).
- Stall/ignore:
  - hold advance=0 for 5 cycles at idx3: round_key and round_idx stable, round_key_valid=1;
  - pulse key_valid with a different key during RUN: not accepted, sequence unchanged;
  - advance in IDLE: no state change.
- Reset mid-operation: assert rst_n=0 asynchronously at idx7 (between clock edges):
  - outputs go to reset values immediately;
  - after release, a new key produces a correct idx0 one cycle after accept.
- Parity (macro defined):
  - key 64'h133457799BBCDFF1 gives parity_err=0;
  - key 64'h133457799BBCDFF0 gives parity_err=1 and the subkeys still match the reference model (parity bits are unused).
  - With the macro undefined, parity_err=0 for both keys.
